// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared widths for the 512-to-64 serializer slice
package serdes_pkg;
    localparam int WORD_W     = 512;
    localparam int LANE_W     = 64;
    localparam int LANES      = WORD_W / LANE_W;
    localparam int LANE_IDX_W = 3;
endpackage

// File: rtl/serializer_512_to_64_if.sv
// rtl/serializer_512_to_64_if.sv - word-in / lane-out bus of the serializer
interface serializer_512_to_64_if
    import serdes_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  clr;
    logic [WORD_W-1:0]     data_in;
    logic                  wr_enable;
    logic                  full;
    logic                  almost_full;
    logic [LANE_W-1:0]     data_out;
    logic                  rd_enable;
    logic                  empty;
    logic [CNT_W-1:0]      word_count;
    logic [LANE_IDX_W-1:0] lane;

    modport master (
        output clr, data_in, wr_enable, rd_enable,
        input  full, almost_full, data_out, empty, word_count, lane
    );

    modport slave (
        input  clr, data_in, wr_enable, rd_enable,
        output full, almost_full, data_out, empty, word_count, lane
    );
endinterface

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - DEPTH x 512-bit first-word-fall-through FIFO
module word_fifo
    import serdes_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);
    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && !clr && push_ok) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/serializer_512_to_64.sv
// rtl/serializer_512_to_64.sv - serializes buffered 512-bit words into eight 64-bit lanes
module serializer_512_to_64
    import serdes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    serializer_512_to_64_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WORD_W-1:0]     head;
    logic [CNT_W-1:0]      count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [LANE_IDX_W-1:0] lane_q;
    logic                  rd_acc;
    logic                  pop;

    assign rd_acc = bus.rd_enable && !fifo_empty;
    // the head word leaves only once its last lane has been consumed
    assign pop    = rd_acc && (lane_q == LANE_IDX_W'(LANES - 1));

    word_fifo #(.DEPTH(DEPTH)) u_word_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (bus.clr),
        .push      (bus.wr_enable),
        .push_data (bus.data_in),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst || bus.clr) lane_q <= '0;
        else if (rd_acc)     lane_q <= lane_q + LANE_IDX_W'(1);
    end

    assign bus.full        = fifo_full;
    assign bus.empty       = fifo_empty;
    assign bus.almost_full = (count >= CNT_W'(DEPTH - 1));
    assign bus.word_count  = count;
    assign bus.lane        = lane_q;
    assign bus.data_out    = fifo_empty ? '0 : head[lane_q*LANE_W +: LANE_W];
endmodule

// File: tb/tb_serializer_512_to_64.sv
// tb/tb_serializer_512_to_64.sv - randomized check of the serializer against a queue model
module tb_serializer_512_to_64;
    import serdes_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [WORD_W-1:0] model_q[$];
    int                model_lane = 0;

    serializer_512_to_64_if #(.DEPTH(DEPTH)) bus ();

    serializer_512_to_64 #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WORD_W-1:0] rand_word();
        logic [WORD_W-1:0] w;
        for (int i = 0; i < WORD_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] ramp_word();
        logic [WORD_W-1:0] w;
        for (int k = 0; k < LANES; k++) w[k*LANE_W +: LANE_W] = 64'h1111_1111_1111_1111 * k;
        return w;
    endfunction

    task automatic check_outputs(input string ctx);
        int n;
        logic [LANE_W-1:0] exp_do;
        logic [WORD_W-1:0] hw;
        n = model_q.size();
        exp_do = '0;
        if (n > 0) begin
            hw = model_q[0];
            exp_do = hw[model_lane*LANE_W +: LANE_W];
        end
        check_val({ctx, ":word_count"}, 512'(bus.word_count), 512'(n));
        check_val({ctx, ":lane"}, 512'(bus.lane), 512'(model_lane));
        check_val({ctx, ":empty"}, 512'(bus.empty), 512'(n == 0));
        check_val({ctx, ":full"}, 512'(bus.full), 512'(n == DEPTH));
        check_val({ctx, ":almost_full"}, 512'(bus.almost_full), 512'(n >= DEPTH - 1));
        check_val({ctx, ":data_out"}, 512'(bus.data_out), 512'(exp_do));
    endtask

    // one clock: drive at the falling edge, advance the model at the rising edge, sample 1 ns later
    task automatic step(input string ctx, input logic w, input logic [WORD_W-1:0] d,
                        input logic r, input logic c = 1'b0, input logic n = 1'b1);
        bit was_full, was_empty;
        @(negedge clk);
        bus.wr_enable = w;
        bus.data_in   = d;
        bus.rd_enable = r;
        bus.clr       = c;
        rst           = n;
        @(posedge clk);
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        if (!n || c) begin
            model_q.delete();
            model_lane = 0;
        end else begin
            if (r && !was_empty) begin
                if (model_lane == LANES - 1) begin
                    void'(model_q.pop_front());
                    model_lane = 0;
                end else begin
                    model_lane++;
                end
            end
            if (w && !was_full) model_q.push_back(d);
        end
        #1;
        check_outputs(ctx);
    endtask

    task automatic idle(input string ctx, input int cycles);
        for (int i = 0; i < cycles; i++) step(ctx, 1'b0, '0, 1'b0);
    endtask

    task automatic drain(input string ctx);
        for (int i = 0; i < 8 * DEPTH + 2; i++) step(ctx, 1'b0, '0, 1'b1);
    endtask

    initial begin
        bus.wr_enable = 1'b0;
        bus.rd_enable = 1'b0;
        bus.clr       = 1'b0;
        bus.data_in   = '0;

        step("reset", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step("reset", 1'b1, rand_word(), 1'b1, 1'b1, 1'b0);

        step("ramp_wr", 1'b1, ramp_word(), 1'b0);
        for (int i = 0; i < 8; i++) step("ramp_rd", 1'b0, '0, 1'b1);
        idle("ramp_idle", 2);

        for (int i = 0; i < 5; i++) step("fill5", 1'b1, rand_word(), 1'b0);
        drain("fill5_drain");

        for (int i = 0; i < DEPTH; i++) step("full_rw_fill", 1'b1, rand_word(), 1'b0);
        for (int i = 0; i < 20; i++) step("full_rw", 1'b1, rand_word(), 1'b1);
        drain("full_rw_drain");

        for (int i = 0; i < 16 * 8 + 2; i++)
            step("steady", (i % 8 == 0) && (i < 16 * 8), rand_word(), 1'b1);

        for (int i = 0; i < 10; i++) step("rd_empty", 1'b0, '0, 1'b1);

        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3; i++) step("abort_fill", 1'b1, rand_word(), 1'b0);
            for (int i = 0; i < 11; i++) step("abort_rd", 1'b0, '0, 1'b1);
            step("abort", 1'b1, rand_word(), 1'b1, pass == 1, pass == 0);
            step("abort_wr", 1'b1, rand_word(), 1'b0);
            drain("abort_drain");
        end

        for (int i = 0; i < 3000; i++)
            step("random", $urandom_range(0, 2) != 0, rand_word(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 199) == 0, $urandom_range(0, 299) != 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serializer_512_to_64.md
SERIALIZER_512_TO_64 -- requirements
Module: serializer_512_to_64

Interface
REQ-001 Parameter: DEPTH, 4, number of 512-bit words stored; power of two, 2..16.
REQ-002 Port: clk  input  1  clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-low.
REQ-004 Port: clr  input  1  synchronous clear, active-high.
REQ-005 Port: data_in  input  512  word to serialize; lane k = data_in[64k+63:64k].
REQ-006 Port: wr_enable  input  1  write request for data_in.
REQ-007 Port: full  output  1  high when word_count == DEPTH.
REQ-008 Port: almost_full  output  1  high when word_count >= DEPTH-1.
REQ-009 Port: data_out  output  64  current lane of head word.
REQ-010 Port: rd_enable  input  1  consume current lane.
REQ-011 Port: empty  output  1  high when word_count == 0.
REQ-012 Port: word_count  output  $clog2(DEPTH+1)  words held, including the partially consumed head.
REQ-013 Port: lane  output  3  index of the lane presented on data_out.

Function
REQ-014 Write accepted when wr_enable=1 and full=0, evaluated on pre-edge state; wr_enable while full is ignored, word dropped, no state change.
REQ-015 First-word-fall-through: accepted word into empty block appears on data_out (lane 0) the cycle after the write edge; empty deasserts the same cycle.
REQ-016 data_out = lane `lane` of head word when empty=0; data_out = 64'h0 when empty=1.
REQ-017 Read accepted when rd_enable=1 and empty=0; rd_enable while empty is ignored.
REQ-018 Accepted read with lane<7: lane increments by 1, head word retained.
REQ-019 Accepted read with lane==7: head word popped, lane wraps to 0, word_count decrements unless a write is accepted the same edge.
REQ-020 Lane order: 0 first, 7 last; exactly 8 accepted reads per word; full throughput one lane per cycle.
REQ-021 Simultaneous accepted write and pop: word_count unchanged; write ordered behind all stored words.
REQ-022 Write while full and pop in the same cycle: write rejected (full from pre-edge state); word_count becomes DEPTH-1.
REQ-023 Write/read pointers wrap modulo DEPTH without losing order.
REQ-024 clr=1 at an edge: word_count=0, lane=0, pointers=0; wr_enable/rd_enable that edge ignored; storage contents need not be cleared.

Reset
REQ-025 rst=0 at an edge: word_count=0, lane=0, pointers=0, empty=1, full=0, almost_full=0 (DEPTH>1), data_out=64'h0; rst dominates clr.
REQ-026 Reset mid-word discards the partially read head and all stored words; no storage reset required.

Structure
REQ-027 Shared package serdes_pkg holds WORD_W=512, LANE_W=64, LANES=8, LANE_IDX_W=3; no local redefinitions.
REQ-028 One sub-module word_fifo: DEPTH x 512-bit synchronous FWFT FIFO with push, pop, count; top holds the lane counter, lane mux and accept logic.

Verification
REQ-029 Reset, then write 0x07..0x00 lanes (lane k = 64'h1111_1111_1111_1111*k): 1 cycle later empty=0, data_out lane0=0; 8 consecutive reads yield 0,1x,...,7x; empty=1 after 8th.
REQ-030 Write 5 words with DEPTH=4, no reads: full=1 after 4th, 5th dropped, word_count=4; drain returns words 1-4 only.
REQ-031 Full, rd_enable held with wr_enable held: on lane-7 pop edge write rejected, word_count=3; next cycle write accepted, word_count=4.
REQ-032 Steady state with one write every 8 cycles and rd_enable constant: word_count stays 1, 16 words stream with no gap, pointers wrap 4 times.
REQ-033 rd_enable while empty for 10 cycles: lane=0, word_count=0, data_out=0 throughout.
REQ-034 rst=0 (then clr=1 in a second run) after 3 lanes of word 2 of 3: word_count=0, lane=0, empty=1; next write presents its lane 0.
